// File: rtl/riscv_ex_dsp_offload.sv
// EX-stage result stage that sits just after the basic ALU.
// Ops the basic ALU can execute pass straight through with no added latency.
// Offloaded ops go to the cluster-shared DSP over a req/gnt request and a
// tagged response, and EX stalls until the result comes back.
//
// Handshake semantics:
//   dsp_req_o/dsp_gnt_i : a request transfers on a cycle where both are high.
//                         The payload (dsp_op_o, dsp_op*_o, dsp_vec_mode_o,
//                         dsp_tag_o) comes from registers and stays stable
//                         while the request waits. The request is withdrawn
//                         without a grant only when the instruction is flushed.
//   dsp_rvalid_i        : a one-cycle response. It is consumed only when
//                         dsp_rtag_i equals the outstanding tag. Responses with
//                         any other tag are ignored in every state.
//   result_valid_o      : result_o/comparison_result_o are valid this cycle.
//                         The result is consumed when ready_o is high.
//                         result_o reads 0 whenever result_valid_o is low.
module riscv_ex_dsp_offload #(
    parameter int ALU_OP_WIDTH   = 7,
    parameter int TAG_WIDTH      = 4,
    parameter int VEC_MODE_WIDTH = 2    // width of the ivec_mode_fmt encoding
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      offload_i,
    input  logic                      flush_i,
    input  logic [ALU_OP_WIDTH-1:0]   operator_i,
    input  logic [31:0]               operand_a_i,
    input  logic [31:0]               operand_b_i,
    input  logic [31:0]               operand_c_i,
    input  logic [VEC_MODE_WIDTH-1:0] vector_mode_i,
    input  logic [31:0]               alu_result_i,
    input  logic                      alu_cmp_i,
    input  logic                      ex_ready_i,
    output logic                      dsp_req_o,
    input  logic                      dsp_gnt_i,
    output logic [ALU_OP_WIDTH-1:0]   dsp_op_o,
    output logic [31:0]               dsp_opa_o,
    output logic [31:0]               dsp_opb_o,
    output logic [31:0]               dsp_opc_o,
    output logic [VEC_MODE_WIDTH-1:0] dsp_vec_mode_o,
    output logic [TAG_WIDTH-1:0]      dsp_tag_o,
    input  logic                      dsp_rvalid_i,
    input  logic [TAG_WIDTH-1:0]      dsp_rtag_i,
    input  logic [31:0]               dsp_rdata_i,
    input  logic                      dsp_rcmp_i,
    output logic [31:0]               result_o,
    output logic                      comparison_result_o,
    output logic                      result_valid_o,
    output logic                      ready_o,
    output logic                      busy_o,
    output logic [2:0]                dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [TAG_WIDTH-1:0]      tag_q;
    logic [ALU_OP_WIDTH-1:0]   op_q;
    logic [31:0]               opa_q, opb_q, opc_q;
    logic [VEC_MODE_WIDTH-1:0] vec_q;
    logic [31:0]               res_q;
    logic                      cmp_q;

    logic launch;
    logic capture;
    logic rsp_match;

    assign rsp_match = dsp_rvalid_i && (dsp_rtag_i == tag_q);

    assign dsp_op_o       = op_q;
    assign dsp_opa_o      = opa_q;
    assign dsp_opb_o      = opb_q;
    assign dsp_opc_o      = opc_q;
    assign dsp_vec_mode_o = vec_q;
    assign dsp_tag_o      = tag_q;
    assign dbg_state_o    = state_q;

    // Next-state and output decode for the offload FSM.
    always_comb begin
        state_d             = state_q;
        launch              = 1'b0;
        capture             = 1'b0;
        result_o            = 32'd0;
        comparison_result_o = 1'b0;
        result_valid_o      = 1'b0;
        ready_o             = 1'b1;
        busy_o              = 1'b0;
        dsp_req_o           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_i && !offload_i && !flush_i) begin
                    result_o            = alu_result_i;
                    comparison_result_o = alu_cmp_i;
                    result_valid_o      = 1'b1;
                    ready_o             = ex_ready_i;
                end else if (en_i && offload_i && !flush_i) begin
                    ready_o = 1'b0;
                    launch  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                dsp_req_o = 1'b1;
                ready_o   = 1'b0;
                busy_o    = 1'b1;
                if (dsp_gnt_i) begin
                    // A granted request still owes a response; a flush drains it.
                    state_d = flush_i ? S_DRAIN : S_WAIT;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                ready_o = 1'b0;
                busy_o  = 1'b1;
                if (rsp_match) begin
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        capture = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                result_valid_o = !flush_i;
                if (!flush_i) begin
                    result_o            = res_q;
                    comparison_result_o = cmp_q;
                end
                ready_o = ex_ready_i || flush_i;
                if (ex_ready_i || flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                // Only passthrough ops proceed while the killed response is outstanding.
                if (en_i && offload_i && !flush_i) begin
                    ready_o = 1'b0;
                end else if (en_i && !offload_i && !flush_i) begin
                    result_o            = alu_result_i;
                    comparison_result_o = alu_cmp_i;
                    result_valid_o      = 1'b1;
                    ready_o             = ex_ready_i;
                end
                if (rsp_match) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, tag, latched request payload and captured response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            vec_q   <= '0;
            res_q   <= '0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                op_q  <= operator_i;
                opa_q <= operand_a_i;
                opb_q <= operand_b_i;
                opc_q <= operand_c_i;
                vec_q <= vector_mode_i;
                tag_q <= tag_q + TAG_WIDTH'(1);
            end
            if (capture) begin
                res_q <= dsp_rdata_i;
                cmp_q <= dsp_rcmp_i;
            end
        end
    end

endmodule

// File: tb/tb_riscv_ex_dsp_offload.sv
// Bench for riscv_ex_dsp_offload. Inputs change just after the falling edge
// and outputs are sampled 1 time unit later, away from the rising edge.
module tb_riscv_ex_dsp_offload;
    localparam int OPW = 7;
    localparam int TW  = 4;
    localparam int VW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           en_i, offload_i, flush_i;
    logic [OPW-1:0] operator_i;
    logic [31:0]    operand_a_i, operand_b_i, operand_c_i;
    logic [VW-1:0]  vector_mode_i;
    logic [31:0]    alu_result_i;
    logic           alu_cmp_i, ex_ready_i;
    logic           dsp_req_o, dsp_gnt_i;
    logic [OPW-1:0] dsp_op_o;
    logic [31:0]    dsp_opa_o, dsp_opb_o, dsp_opc_o;
    logic [VW-1:0]  dsp_vec_mode_o;
    logic [TW-1:0]  dsp_tag_o;
    logic           dsp_rvalid_i;
    logic [TW-1:0]  dsp_rtag_i;
    logic [31:0]    dsp_rdata_i;
    logic           dsp_rcmp_i;
    logic [31:0]    result_o;
    logic           comparison_result_o, result_valid_o, ready_o, busy_o;
    logic [2:0]     dbg_state_o;

    int checks = 0;
    int fails  = 0;
    int launches = 0;           // offloads launched since the last reset
    logic [31:0] exp_q[$];      // expected DSP results, in issue order
    logic        exp_cmp_q[$];

    always #5 clk = ~clk;

    riscv_ex_dsp_offload #(.ALU_OP_WIDTH(OPW), .TAG_WIDTH(TW), .VEC_MODE_WIDTH(VW)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .offload_i(offload_i), .flush_i(flush_i),
        .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .operand_c_i(operand_c_i), .vector_mode_i(vector_mode_i),
        .alu_result_i(alu_result_i), .alu_cmp_i(alu_cmp_i), .ex_ready_i(ex_ready_i),
        .dsp_req_o(dsp_req_o), .dsp_gnt_i(dsp_gnt_i), .dsp_op_o(dsp_op_o),
        .dsp_opa_o(dsp_opa_o), .dsp_opb_o(dsp_opb_o), .dsp_opc_o(dsp_opc_o),
        .dsp_vec_mode_o(dsp_vec_mode_o), .dsp_tag_o(dsp_tag_o),
        .dsp_rvalid_i(dsp_rvalid_i), .dsp_rtag_i(dsp_rtag_i), .dsp_rdata_i(dsp_rdata_i),
        .dsp_rcmp_i(dsp_rcmp_i), .result_o(result_o),
        .comparison_result_o(comparison_result_o), .result_valid_o(result_valid_o),
        .ready_o(ready_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [31:0] model_tag();
        return 32'(launches % 16);
    endfunction

    task automatic set_idle();
        en_i = 1'b0; offload_i = 1'b0; flush_i = 1'b0;
        operator_i = '0; operand_a_i = '0; operand_b_i = '0; operand_c_i = '0;
        vector_mode_i = '0; alu_result_i = '0; alu_cmp_i = 1'b0; ex_ready_i = 1'b1;
        dsp_gnt_i = 1'b0; dsp_rvalid_i = 1'b0; dsp_rtag_i = '0; dsp_rdata_i = '0;
        dsp_rcmp_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        cyc();
        cyc();
        rst = 1'b0;
        launches = 0;
        exp_q.delete();
        exp_cmp_q.delete();
    endtask

    // Present an offload op, check the request, grant it after gdelay extra
    // cycles. Returns at the first WAIT cycle (just after the falling edge + 1).
    task automatic launch_and_grant(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] c, input int gdelay);
        logic [OPW-1:0] op;
        logic [VW-1:0]  vm;
        op = OPW'($urandom_range(0, 127));
        vm = VW'($urandom_range(0, 3));
        en_i = 1'b1; offload_i = 1'b1; flush_i = 1'b0;
        operator_i = op; vector_mode_i = vm;
        operand_a_i = a; operand_b_i = b; operand_c_i = c;
        #1;
        check1("launch_ready", ready_o, 1'b0);
        check1("launch_valid", result_valid_o, 1'b0);
        cyc();
        launches++;
        #1;
        check1("req_assert", dsp_req_o, 1'b1);
        check("req_tag", 32'(dsp_tag_o), model_tag());
        check("req_opa", dsp_opa_o, a);
        check("req_opb", dsp_opb_o, b);
        check("req_opc", dsp_opc_o, c);
        check("req_op", 32'(dsp_op_o), 32'(op));
        check("req_vec", 32'(dsp_vec_mode_o), 32'(vm));
        check1("req_busy", busy_o, 1'b1);
        check1("req_ready", ready_o, 1'b0);
        repeat (gdelay) begin
            cyc();
            #1;
            check1("req_hold", dsp_req_o, 1'b1);
            check("req_tag_hold", 32'(dsp_tag_o), model_tag());
        end
        dsp_gnt_i = 1'b1;
        cyc();
        dsp_gnt_i = 1'b0;
        #1;
        check1("req_drop", dsp_req_o, 1'b0);
        check1("wait_busy", busy_o, 1'b0 == 1'b0);
        check1("wait_ready", ready_o, 1'b0);
    endtask

    // One-cycle DSP response; returns just after the falling edge that follows it.
    task automatic respond(input logic [3:0] tag, input logic [31:0] data, input logic cmp);
        dsp_rvalid_i = 1'b1; dsp_rtag_i = tag; dsp_rdata_i = data; dsp_rcmp_i = cmp;
        #1;
        check1("rsp_cycle_valid", result_valid_o, 1'b0);
        cyc();
        dsp_rvalid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a, b, c, d;
        logic        fl, er;
        int          bp;

        // Reset state
        do_reset();
        #1;
        check1("rst_req", dsp_req_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_ready", ready_o, 1'b1);
        check1("rst_valid", result_valid_o, 1'b0);
        check("rst_tag", 32'(dsp_tag_o), 32'd0);
        check("rst_opa", dsp_opa_o, 32'd0);

        // Passthrough, directed
        cyc();
        en_i = 1'b1; offload_i = 1'b0; alu_result_i = 32'h0000_1234; alu_cmp_i = 1'b1;
        ex_ready_i = 1'b1;
        #1;
        check("pt_result", result_o, 32'h0000_1234);
        check1("pt_cmp", comparison_result_o, 1'b1);
        check1("pt_valid", result_valid_o, 1'b1);
        check1("pt_ready", ready_o, 1'b1);
        check1("pt_req", dsp_req_o, 1'b0);

        // Passthrough, randomized data, flush and backpressure
        for (int i = 0; i < 6; i++) begin
            cyc();
            d = $urandom; fl = 1'($urandom_range(0, 1)); er = 1'($urandom_range(0, 1));
            alu_result_i = d; alu_cmp_i = d[0]; flush_i = fl; ex_ready_i = er;
            #1;
            check("pt_rand_result", result_o, fl ? 32'd0 : d);
            check1("pt_rand_cmp", comparison_result_o, fl ? 1'b0 : d[0]);
            check1("pt_rand_valid", result_valid_o, !fl);
            check1("pt_rand_ready", ready_o, fl ? 1'b1 : er);
            check1("pt_rand_req", dsp_req_o, 1'b0);
        end

        // Offload nominal: A=7, B=6, grant at cycle 3, response at cycle 6
        cyc();
        set_idle();
        launch_and_grant(32'd7, 32'd6, 32'd0, 2);
        cyc();
        cyc();
        respond(4'd1, 32'd42, 1'b0);
        #1;
        check("nom_result", result_o, 32'd42);
        check1("nom_valid", result_valid_o, 1'b1);
        check1("nom_ready", ready_o, 1'b1);
        check1("nom_busy_done", busy_o, 1'b0);
        cyc();
        set_idle();
        #1;
        check1("nom_idle_busy", busy_o, 1'b0);
        check1("nom_idle_valid", result_valid_o, 1'b0);
        check1("nom_idle_ready", ready_o, 1'b1);
        check("nom_no_relaunch_tag", 32'(dsp_tag_o), 32'd1);

        // Backpressure in DONE for 3 cycles
        cyc();
        launch_and_grant(32'd3, 32'd14, 32'd0, 0);
        respond(4'd2, 32'd42, 1'b1);
        ex_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_result_hold", result_o, 32'd42);
            check1("bp_cmp_hold", comparison_result_o, 1'b1);
            check1("bp_valid", result_valid_o, 1'b1);
            check1("bp_ready", ready_o, 1'b0);
            cyc();
        end
        ex_ready_i = 1'b1;
        #1;
        check("bp_result_final", result_o, 32'd42);
        check1("bp_ready_final", ready_o, 1'b1);
        cyc();
        set_idle();
        #1;
        check1("bp_idle_busy", busy_o, 1'b0);
        check1("bp_idle_ready", ready_o, 1'b1);

        // Flush in WAIT -> drain, stale response ignored, passthrough during drain
        cyc();
        launch_and_grant(32'd5, 32'd9, 32'd1, 1);
        flush_i = 1'b1;
        #1;
        check1("fw_flush_valid", result_valid_o, 1'b0);
        cyc();
        set_idle();
        #1;
        check1("drain_busy", busy_o, 1'b1);
        check1("drain_ready", ready_o, 1'b1);
        check1("drain_req", dsp_req_o, 1'b0);
        dsp_rvalid_i = 1'b1; dsp_rtag_i = 4'hF; dsp_rdata_i = 32'hBAD0_BAD0;
        cyc();
        dsp_rvalid_i = 1'b0;
        #1;
        check1("drain_stale_busy", busy_o, 1'b1);
        check1("drain_stale_valid", result_valid_o, 1'b0);
        en_i = 1'b1; offload_i = 1'b0; alu_result_i = 32'h0000_ABCD; alu_cmp_i = 1'b0;
        #1;
        check("drain_pt_result", result_o, 32'h0000_ABCD);
        check1("drain_pt_valid", result_valid_o, 1'b1);
        check1("drain_pt_ready", ready_o, 1'b1);
        cyc();
        offload_i = 1'b1;
        #1;
        check1("drain_offload_stall", ready_o, 1'b0);
        check1("drain_offload_valid", result_valid_o, 1'b0);
        cyc();
        set_idle();
        dsp_rvalid_i = 1'b1; dsp_rtag_i = 4'd3; dsp_rdata_i = 32'h1111_2222;
        #1;
        check1("drain_match_valid", result_valid_o, 1'b0);
        cyc();
        dsp_rvalid_i = 1'b0;
        #1;
        check1("drain_exit_busy", busy_o, 1'b0);
        check1("drain_exit_valid", result_valid_o, 1'b0);
        check1("drain_exit_ready", ready_o, 1'b1);

        // Flush in REQ without grant -> request withdrawn
        cyc();
        en_i = 1'b1; offload_i = 1'b1; operand_a_i = 32'd1; operand_b_i = 32'd2;
        cyc();
        launches++;
        flush_i = 1'b1;
        #1;
        check1("freq_req_before", dsp_req_o, 1'b1);
        check("freq_tag", 32'(dsp_tag_o), model_tag());
        cyc();
        set_idle();
        #1;
        check1("freq_req_after", dsp_req_o, 1'b0);
        check1("freq_busy_after", busy_o, 1'b0);
        check1("freq_ready_after", ready_o, 1'b1);

        // Flush in REQ together with grant -> drain until matching response
        cyc();
        launch_and_grant(32'd8, 32'd8, 32'd8, 0);
        cyc();
        set_idle();
        dsp_gnt_i = 1'b0;
        cyc();
        // The previous task granted without a flush, so this one uses flush+grant directly.
        launches++;
        en_i = 1'b1; offload_i = 1'b1;
        respond(4'(launches - 1), 32'd0, 1'b0);
        // respond() landed on the DONE of the previous op; retire it.
        set_idle();
        cyc();
        en_i = 1'b1; offload_i = 1'b1; operand_a_i = 32'd4;
        cyc();
        #1;
        check1("fgnt_req", dsp_req_o, 1'b1);
        check("fgnt_tag", 32'(dsp_tag_o), model_tag());
        dsp_gnt_i = 1'b1; flush_i = 1'b1;
        cyc();
        set_idle();
        #1;
        check1("fgnt_drain_busy", busy_o, 1'b1);
        check1("fgnt_drain_req", dsp_req_o, 1'b0);
        dsp_rvalid_i = 1'b1; dsp_rtag_i = 4'(launches); dsp_rdata_i = 32'h5555_5555;
        cyc();
        dsp_rvalid_i = 1'b0;
        #1;
        check1("fgnt_exit_busy", busy_o, 1'b0);
        check1("fgnt_exit_valid", result_valid_o, 1'b0);

        // Flush while in DONE -> result dropped, EX advances
        cyc();
        launch_and_grant(32'd2, 32'd3, 32'd0, 0);
        respond(4'(launches), 32'h7777_0000, 1'b1);
        flush_i = 1'b1; ex_ready_i = 1'b0;
        #1;
        check1("fdone_valid", result_valid_o, 1'b0);
        check("fdone_result", result_o, 32'd0);
        check1("fdone_ready", ready_o, 1'b1);
        cyc();
        set_idle();
        #1;
        check1("fdone_idle_busy", busy_o, 1'b0);
        check1("fdone_idle_valid", result_valid_o, 1'b0);

        // Tag wrap: 17 back-to-back random offloads after a fresh reset
        do_reset();
        for (int n = 0; n < 17; n++) begin
            a = $urandom; b = $urandom; c = $urandom;
            exp_q.push_back(a * b + c);
            exp_cmp_q.push_back(a < b);
            launch_and_grant(a, b, c, $urandom_range(0, 2));
            check("wrap_tag_seq", 32'(dsp_tag_o), 32'((n + 1) % 16));
            repeat ($urandom_range(0, 2)) begin
                cyc();
                #1;
                check1("wrap_wait_valid", result_valid_o, 1'b0);
            end
            // A response carrying the previous tag must be ignored
            dsp_rvalid_i = 1'b1; dsp_rtag_i = 4'((launches + 15) % 16);
            dsp_rdata_i = 32'hDEAD_BEEF;
            cyc();
            dsp_rvalid_i = 1'b0;
            #1;
            check1("wrap_stale_valid", result_valid_o, 1'b0);
            check1("wrap_stale_busy", busy_o, 1'b1);
            // Shared DSP behaviour: multiply-accumulate on the operands it was handed
            respond(4'(model_tag()), dsp_opa_o * dsp_opb_o + dsp_opc_o, dsp_opa_o < dsp_opb_o);
            bp = $urandom_range(0, 2);
            ex_ready_i = 1'b0;
            repeat (bp) begin
                #1;
                check("wrap_hold_result", result_o, exp_q[0]);
                check1("wrap_hold_ready", ready_o, 1'b0);
                cyc();
            end
            ex_ready_i = 1'b1;
            #1;
            check("wrap_result", result_o, exp_q.pop_front());
            check1("wrap_cmp", comparison_result_o, exp_cmp_q.pop_front());
            check1("wrap_valid", result_valid_o, 1'b1);
            check1("wrap_ready", ready_o, 1'b1);
            cyc();
        end
        set_idle();
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while waiting for a response
        launch_and_grant(32'd11, 32'd12, 32'd13, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set_idle();
        launches = 0;
        #1;
        check1("rstw_req", dsp_req_o, 1'b0);
        check1("rstw_busy", busy_o, 1'b0);
        check1("rstw_ready", ready_o, 1'b1);
        check("rstw_tag", 32'(dsp_tag_o), model_tag());
        check("rstw_opa", dsp_opa_o, 32'd0);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
